// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit and its lane aligner.
package mem_access_pkg;

    localparam int unsigned MAU_ADDR_W = 7;
    localparam int unsigned MAU_DATA_W = 32;
    localparam int unsigned MAU_STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_ILL
    } size_e;

    // True when the access does not sit on its natural boundary.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lsb);
        case (size)
            SZ_HALF: return lsb[0];
            SZ_WORD: return |lsb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte/half lane extract-and-extend for loads and lane merge for stores.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [MAU_DATA_W-1:0] rdata,
    input  logic [MAU_DATA_W-1:0] wdata,
    input  size_e                 size,
    input  logic [1:0]            lsb,
    input  logic                  is_unsigned,
    output logic [MAU_DATA_W-1:0] load_data_c,
    output logic [MAU_DATA_W-1:0] merge_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and half-word from the memory word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (lsb)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lsb[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign- or zero-extend the selected field.
    always_comb begin
        load_data_c = rdata;
        case (size)
            SZ_BYTE: load_data_c = is_unsigned ? {24'h0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_c = is_unsigned ? {16'h0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default: load_data_c = rdata;
        endcase
    end

    // Replace the addressed lane of the old word with the store data.
    always_comb begin
        merge_data_c = rdata;
        case (size)
            SZ_BYTE: begin
                case (lsb)
                    2'd1:    merge_data_c[15:8]  = wdata[7:0];
                    2'd2:    merge_data_c[23:16] = wdata[7:0];
                    2'd3:    merge_data_c[31:24] = wdata[7:0];
                    default: merge_data_c[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lsb[1]) merge_data_c[31:16] = wdata[15:0];
                else        merge_data_c[15:0]  = wdata[15:0];
            end
            default: merge_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store controller for a single-cycle word SRAM (read-modify-write
// for sub-word stores). Optional counters: define MEM_ACCESS_STATS_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = MAU_ADDR_W,
    parameter int unsigned DATA_W = MAU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [MAU_STAT_W-1:0] stat_loads,
    output logic [MAU_STAT_W-1:0] stat_stores,
    output logic [MAU_STAT_W-1:0] stat_errs
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    size_e             size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic              resp_valid_d, resp_err_d, mem_we_d;
    logic [DATA_W-1:0] resp_rdata_d;
    logic [DATA_W-1:0] load_data_c, merge_data_c;
    size_e             req_size_e;

    assign req_size_e = size_e'(req_size);
    assign mem_raddr  = addr_q[ADDR_W+1:2];
    assign mem_waddr  = addr_q[ADDR_W+1:2];
    assign mem_wdata  = wdata_q;

    lane_align u_lane_align (
        .rdata        (mem_rdata),
        .wdata        (wdata_q),
        .size         (size_q),
        .lsb          (addr_q[1:0]),
        .is_unsigned  (uns_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state, captured request fields and next output values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        write_d      = write_q;
        uns_d        = uns_q;
        resp_valid_d = resp_valid;
        resp_err_d   = resp_err;
        resp_rdata_d = resp_rdata;
        mem_we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size_e;
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    if (req_size_e == SZ_ILL || is_misaligned(req_size_e, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_write && req_size_e == SZ_WORD) begin
                        state_d  = WRITE;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    wdata_d  = merge_data_c;
                    state_d  = WRITE;
                    mem_we_d = 1'b1;
                end else begin
                    resp_rdata_d = load_data_c;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_BYTE;
            write_q    <= 1'b0;
            uns_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_we     <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            write_q    <= write_d;
            uns_q      <= uns_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_we     <= mem_we_d;
            req_ready  <= (state_d == IDLE);
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    // Count completed responses by class; errors take precedence over direction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_err)     stat_errs   <= stat_errs   + MAU_STAT_W'(1);
            else if (write_q) stat_stores <= stat_stores + MAU_STAT_W'(1);
            else              stat_loads  <= stat_loads  + MAU_STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: SRAM model, byte-level reference model,
// directed test-plan steps followed by random traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [6:0]  mem_raddr, mem_waddr;
    logic [31:0] mem_rdata, mem_wdata;
    logic        mem_we;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

    logic [31:0] sram    [128];
    logic [31:0] ref_mem [128];
    int          we_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_loads = 0, n_stores = 0, n_errs = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errs    (stat_errs)
`endif
    );

    assign mem_rdata = sram[mem_raddr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            sram[mem_waddr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [8:0] a);
        logic [31:0] word, v;
        int sh;
        word = ref_mem[a[8:2]];
        if (sz == 2'd0) begin
            sh = int'(a[1:0]) * 8;
            v  = (word >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = int'(a[1]) * 16;
            v  = (word >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) begin
            sh   = int'(a[1:0]) * 8;
            mask = 32'hFF << sh;
            ref_mem[a[8:2]] = (ref_mem[a[8:2]] & ~mask) | ((d & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh   = int'(a[1]) * 16;
            mask = 32'hFFFF << sh;
            ref_mem[a[8:2]] = (ref_mem[a[8:2]] & ~mask) | ((d & 32'hFFFF) << sh);
        end else begin
            ref_mem[a[8:2]] = d;
        end
    endtask

    // One complete request/response exchange, checked against the model.
    task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [8:0] a,
                       input logic [31:0] d, input int hold, output logic [31:0] got);
        logic        e;
        logic [31:0] exp_rd;
        int          exp_lat, lat, we0;
        e       = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        exp_rd  = (w || e) ? 32'h0 : ref_load(sz, u, a);
        exp_lat = e ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        we0     = we_cnt;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err), 32'(e));
        check("resp_rdata", resp_rdata, exp_rd);
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_err", 32'(resp_err), 32'(e));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_done", 32'(resp_valid), 32'd0);
        check("we_pulses", 32'(we_cnt - we0), (w && !e) ? 32'd1 : 32'd0);
        if (e)      n_errs++;
        else if (w) begin n_stores++; ref_store(sz, a, d); end
        else        n_loads++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] r;
        logic        w, u;
        logic [1:0]  sz;
        logic [8:0]  a;

        for (int i = 0; i < 128; i++) begin
            r = $urandom;
            sram[i] = r;
            ref_mem[i] = r;
        end
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Word store then word load.
        txn(1'b1, 2'd2, 1'b0, 9'h010, 32'hDEAD_BEEF, 0, got);
        check("word_store_waddr", 32'(mem_waddr), 32'd4);
        txn(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 0, got);
        check("word_load", got, 32'hDEAD_BEEF);

        // Byte store read-modify-write.
        txn(1'b1, 2'd0, 1'b0, 9'h013, 32'h0000_005A, 0, got);
        txn(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 0, got);
        check("rmw_word", got, 32'h5AAD_BEEF);

        // Sign and zero extension.
        txn(1'b0, 2'd0, 1'b0, 9'h013, 32'h0, 0, got);
        check("byte_signed_pos", got, 32'h0000_005A);
        txn(1'b1, 2'd0, 1'b0, 9'h012, 32'h0000_0080, 0, got);
        txn(1'b0, 2'd0, 1'b0, 9'h012, 32'h0, 0, got);
        check("byte_signed_neg", got, 32'hFFFF_FF80);
        txn(1'b0, 2'd0, 1'b1, 9'h012, 32'h0, 0, got);
        check("byte_unsigned", got, 32'h0000_0080);

        // Error cases never touch memory.
        txn(1'b0, 2'd1, 1'b0, 9'h011, 32'h0, 0, got);
        txn(1'b1, 2'd2, 1'b0, 9'h022, 32'h1234_5678, 0, got);
        txn(1'b1, 2'd3, 1'b0, 9'h020, 32'h1234_5678, 1, got);
        txn(1'b0, 2'd2, 1'b0, 9'h020, 32'h0, 0, got);
        check("err_mem_unchanged", got, ref_mem[8]);

        // Back-pressure on the response.
        txn(1'b0, 2'd1, 1'b0, 9'h012, 32'h0, 5, got);
        check("half_upper_signed", got, 32'h0000_5A80);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 9'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            txn(w, sz, u, a, $urandom, $urandom_range(0, 2), got);
        end

        for (int i = 0; i < 128; i++) check("mem_contents", sram[i], ref_mem[i]);

`ifdef MEM_ACCESS_STATS_EN
        check("stat_loads", 32'(stat_loads), 32'(n_loads % 65536));
        check("stat_stores", 32'(stat_stores), 32'(n_stores % 65536));
        check("stat_errs", 32'(stat_errs), 32'(n_errs % 65536));
`endif

        // Reset during the WRITE cycle of a byte store abandons it.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 9'h041; req_wdata = 32'h0000_00C3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rmw_in_write", 32'(mem_we), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
`ifdef MEM_ACCESS_STATS_EN
        check("abort_stat_loads", 32'(stat_loads), 32'd0);
`endif
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        txn(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 0, got);
        check("post_reset_load", got, ref_mem[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the 128x32 single-cycle word SRAM.
- Accepts byte/half/word load and store requests from the CPU over a valid/ready handshake and drives one SRAM read port and the SRAM write port.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Misaligned or illegal-size requests get an error response and never touch memory.

Parameters:
- ADDR_W, 7, SRAM word-address width; the byte address is ADDR_W+2 bits.
- DATA_W, 32, SRAM word width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size
- mem_raddr  out  ADDR_W  to the SRAM read1 address
- mem_rdata  in  DATA_W  from the SRAM read1 data (combinational read)
- mem_waddr  out  ADDR_W  SRAM write address
- mem_wdata  out  DATA_W  SRAM write data
- mem_we  out  1  SRAM write enable

Behaviour:
- Reset (sampled at posedge clk with reset==0): go to IDLE; resp_valid, resp_err, resp_rdata, mem_we and all captured registers are 0. Reset mid-operation abandons the transaction; any write not yet clocked is dropped.
- Handshake: req_ready = (state==IDLE). A request is accepted when req_valid && req_ready; all req_* fields are captured on acceptance. Only one transaction is outstanding at a time.
- States: IDLE, READ, WRITE, RESP.
- IDLE, on accept:
  - misaligned (half with addr[0]!=0, word with addr[1:0]!=0) or size 11 -> RESP with err=1;
  - word store -> WRITE;
  - otherwise -> READ.
- READ:
  - mem_raddr = captured addr[ADDR_W+1:2]; mem_rdata is registered at the end of the cycle.
  - Load: extract the lane selected by addr[1:0], extend it, go to RESP.
  - Sub-word store: merge req_wdata into the selected lane, go to WRITE.
- WRITE: mem_we=1 for exactly one cycle, mem_waddr = word address, mem_wdata = merged word (or full word) -> RESP.
- RESP: resp_valid=1 with outputs held stable until resp_ready; on the resp_ready cycle go to IDLE. A new request can be accepted the following cycle.
- Latency from accept to resp_valid:
  - load: 2 cycles;
  - sub-word store: 3 cycles;
  - word store: 2 cycles;
  - error: 1 cycle.
- Write-then-read ordering: a load following a store reads the updated word, because the SRAM commits at the WRITE posedge before any later READ.
- Lane rules: byte lane k = bits [8k+7:8k]; half lane uses addr[1]. Sign extension takes the MSB of the extracted field.
- mem_raddr may be driven with the captured address in every state; mem_we is 0 outside WRITE.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores and stat_errs, each 16 bits. Each counter increments once on response completion (resp_valid && resp_ready) of its class, wraps modulo 2^16, and clears on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_access_pkg holds:
  - state_e enum (IDLE, READ, WRITE, RESP);
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL);
  - function is_misaligned(size, addr[1:0]).
- One sub-module, lane_align: combinational extract/extend for loads and lane merge for stores. It is reused by the future fetch path.

Test Plan:
- Word store addr 0x010, data 0xDEADBEEF, then word load 0x010 -> one mem_we pulse at waddr 4; load rdata 0xDEADBEEF, err 0, 2-cycle latency.
- Byte store 0x5A to 0x013 over 0xDEADBEEF, then word load 0x010 -> 0x5AADBEEF; READ precedes WRITE.
- Byte load 0x013 signed -> 0x0000005A. Store 0x80 to 0x012, then load signed -> 0xFFFFFF80, unsigned -> 0x00000080.
- Half load 0x011 and word store 0x022 -> resp_err=1 after 1 cycle, rdata 0, mem_we never asserted, memory unchanged.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0 throughout. Pull reset low during WRITE of a pending byte store -> mem_we=0 the next cycle, state IDLE, no response issued.
- With MEM_ACCESS_STATS_EN: 3 loads, 2 stores, 1 error -> stat_loads=3, stat_stores=2, stat_errs=1.
